geofence_feeder: RTL
====================

// Module: geofence_feeder
// PURPOSE
//  Upstream sequencer for the geofence core. Fetches groups of 7 points (target, then 6 receivers) from a
//  sync-read memory, buffers one group, and replays it on X/Y in the exact cycles the core samples.
//  Tracks core slot phase; qualifies core valid/is_inside into indexed results, dropping filler-slot results.
// PARAMETERS
//  AW       12    memory address width (words)
//  TIMEOUT  1023  max cycles in WAIT for core_valid before err
// PORTS
//  clk          in   1   clock (the only clock)
//  reset        in   1   synchronous, active-high reset
//  start        in   1   job request; accepted only when busy=0
//  base_addr    in   AW  first word of group 0; sampled on accepted start
//  num_groups   in   8   groups in job; sampled on accepted start
//  mem_rd       out  1   memory read strobe
//  mem_addr     out  AW  read address
//  mem_data     in   20  {X[19:10],Y[9:0]}, valid cycle after mem_rd
//  X, Y         out  10  point stream to core
//  core_valid   in   1   core result strobe
//  core_inside  in   1   core result, sampled with core_valid
//  res_valid    out  1   qualified result strobe
//  res_inside   out  1   qualified result
//  res_index    out  8   group number of result
//  busy         out  1   job in progress
//  done         out  1   1-cycle job-complete pulse
//  err          out  1   sticky timeout flag, cleared by accepted start
// BEHAVIOUR
//  Reset: all outputs 0 except X/Y = DUMMY target; phase=SLOT_T; buffer empty; job idle.
//  Phase FSM (runs always, mirrors core): SLOT_T(1 cyc, drive word0) -> SLOT_R(6 cyc, words1..6)
//   -> WAIT (until core_valid=1) -> SLOT_T next cycle. Core sees target on cycle after reset release
//   and on cycle after each core_valid cycle.
//  Slot content fixed on entry to SLOT_T: buffer full -> real slot (buffer drained, tag=group idx);
//   else dummy slot (DUMMY_* constants). No mixing within a slot.
//  DUMMY set: hexagon ordered so cross(Pi-P0,Pi+1-P0)<0 for i=1..4 (core sorts with no swaps).
//  Fetch: when job active, buffer empty and group remaining, issue 7 consecutive reads from
//   base_addr+7*g (mod 2^AW), one per cycle; capture data next cycle; full after 7th capture.
//   Fetch may overlap any phase except a slot draining the same buffer.
//  Results: core_valid of real slot -> res_valid=1 next cycle with res_inside, res_index=tag.
//   Dummy-slot results never reach res_valid.
//  done: pulses cycle after last res_valid; busy falls same cycle. num_groups=0: done cycle after
//   start, no mem_rd.
//  start while busy: ignored, no latch.
//  Timeout: WAIT counter > TIMEOUT -> err=1, job aborted (busy=0, no done), buffer cleared;
//   phase stays WAIT until core_valid to keep alignment.
//  Reset mid-operation: job, buffer, counters, err cleared; phase restarts at SLOT_T (core shares reset).
// STRUCTURE
//  geofence_pkg: COORD_W=10, PTS_PER_GROUP=7, DUMMY_X/Y[0:6], phase enum {SLOT_T,SLOT_R,WAIT}.
//  Sub-module geofence_fetch: address gen, read strobe, 7x20b buffer, full flag. Top: phase FSM,
//   tag tracking, result qualify, timeout.
// TESTING (bench pairs feeder with real geofence core + behavioural memory)
//  No start after reset -> dummy slots only, core_valid periodic, res_valid never 1.
//  base=0,num=1, target (50,50) in hexagon (10..90) -> res_valid=1,res_inside=1,index=0, done next cycle.
//  num=3, groups in/out/in -> results 1,0,1 at index 0,1,2; each of addr 0..20 read exactly once.
//  num_groups=0 -> done 1 cycle after start; mem_rd never 1.
//  base=2^AW-3 -> addresses wrap to 0..3 for group 0; correct result.
//  Stub core_valid=0, TIMEOUT=15 -> err=1 after 16 WAIT cycles; busy=0; restart clears err.
//  Reset in SLOT_R 3rd cycle -> outputs 0 next cycle; core sees DUMMY target first cycle after release.

Source files
------------

// File: rtl/geofence_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : geofence_pkg
//  Purpose  : Shared constants for the geofence feeder: coordinate widths,
//             group size, the dummy hexagon and the slot-phase encoding.
//  Revision : 1.0  initial release
// ============================================================================
package geofence_pkg;

    localparam int COORD_W       = 10;
    localparam int WORD_W        = 2 * COORD_W;
    localparam int PTS_PER_GROUP = 7;

    localparam logic [2:0] LAST_IDX = 3'd6;

    localparam logic [1:0] SLOT_T = 2'd0;
    localparam logic [1:0] SLOT_R = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    // Receivers run clockwise, so every cross product about receiver 1 is
    // negative and the core's sorter never has to swap anything.
    localparam logic [COORD_W-1:0] DUMMY_X [PTS_PER_GROUP] =
        '{10'd512, 10'd30, 10'd10, 10'd30, 10'd70, 10'd90, 10'd70};
    localparam logic [COORD_W-1:0] DUMMY_Y [PTS_PER_GROUP] =
        '{10'd3,   10'd10, 10'd50, 10'd90, 10'd90, 10'd50, 10'd10};

    function automatic logic [WORD_W-1:0] dummy_word(input logic [2:0] idx);
        return {DUMMY_X[idx], DUMMY_Y[idx]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/geofence_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : geofence_fetch
//  Purpose  : Reads one 7-word group from sync-read memory into a buffer.
//  Revision : 1.0  initial release
// ============================================================================
module geofence_fetch
    import geofence_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              launch,
    input  logic [AW-1:0]     launch_addr,
    input  logic              drain,
    input  logic [2:0]        rd_idx,
    output logic [WORD_W-1:0] rd_word,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic              busy,
    output logic              full
);

    logic              active_q, active_d;
    logic [2:0]        rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              cap_v_q, cap_v_d;
    logic [2:0]        cap_idx_q, cap_idx_d;
    logic              full_q, full_d;
    logic [WORD_W-1:0] pts_q [PTS_PER_GROUP];
    logic [WORD_W-1:0] pts_d [PTS_PER_GROUP];

    always_comb begin
        active_d  = active_q;
        rd_cnt_d  = rd_cnt_q;
        addr_d    = addr_q;
        full_d    = full_q;
        pts_d     = pts_q;
        cap_v_d   = active_q;
        cap_idx_d = rd_cnt_q;

        if (active_q) begin
            addr_d   = addr_q + AW'(1);
            rd_cnt_d = rd_cnt_q + 3'd1;
            if (rd_cnt_q == LAST_IDX) begin
                active_d = 1'b0;
            end
        end else if (launch) begin
            active_d = 1'b1;
            addr_d   = launch_addr;
            rd_cnt_d = 3'd0;
        end

        // Memory answers one cycle after the strobe
        if (cap_v_q) begin
            pts_d[cap_idx_q] = mem_data;
            if (cap_idx_q == LAST_IDX) begin
                full_d = 1'b1;
            end
        end

        if (drain) begin
            full_d = 1'b0;
        end

        if (clear) begin
            active_d = 1'b0;
            cap_v_d  = 1'b0;
            full_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 1'b0;
            rd_cnt_q  <= 3'd0;
            addr_q    <= '0;
            cap_v_q   <= 1'b0;
            cap_idx_q <= 3'd0;
            full_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            rd_cnt_q  <= rd_cnt_d;
            addr_q    <= addr_d;
            cap_v_q   <= cap_v_d;
            cap_idx_q <= cap_idx_d;
            full_q    <= full_d;
        end
        pts_q <= pts_d;
    end

    assign rd_word  = pts_q[rd_idx];
    assign mem_rd   = active_q;
    assign mem_addr = addr_q;
    assign busy     = active_q | cap_v_q;
    assign full     = full_q;

endmodule
`default_nettype wire

// File: rtl/geofence_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : geofence_feeder
//  Purpose  : Sequences point groups into the geofence core in lock-step with
//             its slot phase and turns core results into indexed results.
//  Revision : 1.0  initial release
// ============================================================================
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int AW      = 12,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [7:0]          num_groups,
    output logic                mem_rd,
    output logic [AW-1:0]       mem_addr,
    input  logic [WORD_W-1:0]   mem_data,
    output logic [COORD_W-1:0]  X,
    output logic [COORD_W-1:0]  Y,
    input  logic                core_valid,
    input  logic                core_inside,
    output logic                res_valid,
    output logic                res_inside,
    output logic [7:0]          res_index,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int             WCW       = $clog2(TIMEOUT + 2);
    localparam logic [WCW-1:0] C_TIMEOUT = WCW'(TIMEOUT);

    logic [1:0]        phase_q, phase_d;
    logic [2:0]        idx_q, idx_d;
    logic              slot_real_q, slot_real_d;
    logic [7:0]        slot_tag_q, slot_tag_d;
    logic              job_q, job_d;
    logic [7:0]        num_q, num_d;
    logic [7:0]        fetched_q, fetched_d;
    logic [7:0]        drained_q, drained_d;
    logic [7:0]        res_cnt_q, res_cnt_d;
    logic [AW-1:0]     next_addr_q, next_addr_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              res_valid_q, res_valid_d;
    logic              res_inside_q, res_inside_d;
    logic [7:0]        res_index_q, res_index_d;

    logic              launch, drain, abort;
    logic              f_busy, f_full;
    logic [WORD_W-1:0] f_word, out_word;

    always_comb begin
        phase_d      = phase_q;
        idx_d        = idx_q;
        slot_real_d  = slot_real_q;
        slot_tag_d   = slot_tag_q;
        job_d        = job_q;
        num_d        = num_q;
        fetched_d    = fetched_q;
        drained_d    = drained_q;
        res_cnt_d    = res_cnt_q;
        next_addr_d  = next_addr_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        done_d       = 1'b0;
        res_valid_d  = 1'b0;
        res_inside_d = res_inside_q;
        res_index_d  = res_index_q;
        launch       = 1'b0;
        drain        = 1'b0;
        abort        = 1'b0;

        // Slot contents are decided once, on the edge into SLOT_T
        case (phase_q)
            SLOT_T: begin
                phase_d = SLOT_R;
                idx_d   = 3'd1;
            end
            SLOT_R: begin
                if (idx_q == LAST_IDX) begin
                    phase_d = WAIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: begin
                if (core_valid) begin
                    phase_d = SLOT_T;
                    idx_d   = 3'd0;
                    if (job_q && f_full) begin
                        slot_real_d = 1'b1;
                        slot_tag_d  = drained_q;
                        drained_d   = drained_q + 8'd1;
                        drain       = 1'b1;
                    end else begin
                        slot_real_d = 1'b0;
                    end
                end
            end
        endcase

        if (phase_q == WAIT && !core_valid) begin
            if (wait_cnt_q <= C_TIMEOUT) begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
            end
        end else begin
            wait_cnt_d = '0;
        end

        if (phase_q == WAIT && core_valid && slot_real_q && job_q) begin
            res_valid_d  = 1'b1;
            res_inside_d = core_inside;
            res_index_d  = slot_tag_q;
        end

        if (job_q) begin
            if (res_valid_q) begin
                res_cnt_d = res_cnt_q + 8'd1;
                if (res_cnt_q == num_q - 8'd1) begin
                    done_d = 1'b1;
                    job_d  = 1'b0;
                end
            end
            if (phase_q == WAIT && !core_valid && wait_cnt_q == C_TIMEOUT) begin
                abort       = 1'b1;
                job_d       = 1'b0;
                err_d       = 1'b1;
                slot_real_d = 1'b0;
            end
            // Never refill while a real slot is still reading the buffer
            launch = job_d && !f_busy && !f_full && (fetched_q != num_q)
                     && !(slot_real_q && phase_q != WAIT);
            if (launch) begin
                fetched_d   = fetched_q + 8'd1;
                next_addr_d = next_addr_q + AW'(PTS_PER_GROUP);
            end
        end else if (start) begin
            err_d = 1'b0;
            if (num_groups == 8'd0) begin
                done_d = 1'b1;
            end else begin
                job_d       = 1'b1;
                num_d       = num_groups;
                next_addr_d = base_addr;
                fetched_d   = 8'd0;
                drained_d   = 8'd0;
                res_cnt_d   = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= SLOT_T;
            idx_q        <= 3'd0;
            slot_real_q  <= 1'b0;
            slot_tag_q   <= 8'd0;
            job_q        <= 1'b0;
            num_q        <= 8'd0;
            fetched_q    <= 8'd0;
            drained_q    <= 8'd0;
            res_cnt_q    <= 8'd0;
            next_addr_q  <= '0;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            res_index_q  <= 8'd0;
        end else begin
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            slot_real_q  <= slot_real_d;
            slot_tag_q   <= slot_tag_d;
            job_q        <= job_d;
            num_q        <= num_d;
            fetched_q    <= fetched_d;
            drained_q    <= drained_d;
            res_cnt_q    <= res_cnt_d;
            next_addr_q  <= next_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
            done_q       <= done_d;
            res_valid_q  <= res_valid_d;
            res_inside_q <= res_inside_d;
            res_index_q  <= res_index_d;
        end
    end

    geofence_fetch #(
        .AW (AW)
    ) u_fetch (
        .clk         (clk),
        .reset       (reset),
        .clear       (abort),
        .launch      (launch),
        .launch_addr (next_addr_q),
        .drain       (drain),
        .rd_idx      (idx_q),
        .rd_word     (f_word),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .busy        (f_busy),
        .full        (f_full)
    );

    always_comb begin
        if (phase_q == WAIT) begin
            out_word = dummy_word(3'd0);
        end else if (slot_real_q) begin
            out_word = f_word;
        end else begin
            out_word = dummy_word(idx_q);
        end
    end

    assign X          = out_word[WORD_W-1:COORD_W];
    assign Y          = out_word[COORD_W-1:0];
    assign res_valid  = res_valid_q;
    assign res_inside = res_inside_q;
    assign res_index  = res_index_q;
    assign busy       = job_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire
